// File: rtl/rx_cdr_pkg.sv
// Shared types and sizing helpers for the post-CORDIC receive back-end.
package rx_cdr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    FRAME  = 2'd2
  } rx_state_e;

  localparam logic [7:0]  DEFAULT_SFD = 8'hA7;
  localparam int unsigned LEN_W       = 7;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rx_bit_timing.sv
// Bit timing recovery: phase counter, edge detection, edge-spacing tolerance
// check, mid-bit decision and run-length lock-loss detection.
module rx_bit_timing
  import rx_cdr_pkg::*;
#(
  parameter int unsigned OSR      = 8,
  parameter int unsigned LOCK_TOL = 1,
  parameter int unsigned MAX_RUN  = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_dir,
  input  logic i_dir_valid,
  output logic edge_c,
  output logic tol_ok_c,
  output logic dec_c,
  output logic dec_bit_c,
  output logic run_lost_c
);

  localparam int unsigned PH_W    = cnt_w(OSR - 1);
  localparam int unsigned RUN_LIM = OSR * MAX_RUN + LOCK_TOL;
  localparam int unsigned SP_MAX  = RUN_LIM + 1;
  localparam int unsigned SP_W    = cnt_w(SP_MAX);

  logic [PH_W-1:0] ph_q;
  logic [SP_W-1:0] sp_q;
  logic            prev_q;

  assign edge_c     = i_dir_valid && (i_dir != prev_q);
  assign dec_c      = i_dir_valid && (ph_q == PH_W'(OSR / 2));
  assign dec_bit_c  = i_dir;
  // Spacing already past the longest legal run and still no edge.
  assign run_lost_c = i_dir_valid && !edge_c && (sp_q >= SP_W'(RUN_LIM));

  // Spacing is acceptable when it lands within LOCK_TOL of any k*OSR.
  always_comb begin
    tol_ok_c = 1'b0;
    for (int unsigned k = 1; k <= MAX_RUN; k++) begin
      if ((32'(sp_q) + LOCK_TOL >= k * OSR) && (32'(sp_q) <= k * OSR + LOCK_TOL)) begin
        tol_ok_c = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ph_q   <= '0;
      sp_q   <= '0;
      prev_q <= 1'b0;
    end else if (i_dir_valid) begin
      prev_q <= i_dir;
      if (edge_c) begin
        ph_q <= PH_W'(1);
      end else if (ph_q == PH_W'(OSR - 1)) begin
        ph_q <= '0;
      end else begin
        ph_q <= ph_q + PH_W'(1);
      end
      if (edge_c) begin
        sp_q <= SP_W'(1);
      end else if (sp_q != SP_W'(SP_MAX)) begin
        sp_q <= sp_q + SP_W'(1);
      end
    end
  end

endmodule

// File: rtl/rx_cdr_framer.sv
// CDR + framer: lock FSM, SFD hunt, length-prefixed byte packing, valid/ready
// output. Define RX_STATS_EN to add frame/drop counters.
module rx_cdr_framer
  import rx_cdr_pkg::*;
#(
  parameter int unsigned OSR      = 8,
  parameter int unsigned LOCK_TOL = 1,
  parameter int unsigned SYNC_LEN = 16,
  parameter logic [7:0]  SFD      = DEFAULT_SFD,
  parameter int unsigned MAX_RUN  = 8,
  parameter int unsigned BYTE_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dir,
  input  logic              i_dir_valid,
  output logic              o_bit,
  output logic              o_bit_valid,
  output logic              o_locked,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_overflow
`ifdef RX_STATS_EN
  ,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_drop_cnt
`endif
);

  localparam int unsigned BC_W = cnt_w(BYTE_W - 1);
  localparam int unsigned SC_W = cnt_w(SYNC_LEN);

  logic edge_c, tol_ok_c, dec_c, dec_bit_c, run_lost_c;
  logic sof_c, eof_c, done_c;

  rx_state_e         state_q, state_d;
  logic [SC_W-1:0]   sync_q;
  logic [7:0]        sfd_q, sfd_nx_c;
  logic [BYTE_W-1:0] pk_q, byte_c;
  logic [BC_W-1:0]   bcnt_q;
  logic              hdr_q;
  logic [LEN_W-1:0]  rem_q;

  rx_bit_timing #(
    .OSR      (OSR),
    .LOCK_TOL (LOCK_TOL),
    .MAX_RUN  (MAX_RUN)
  ) u_timing (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_dir       (i_dir),
    .i_dir_valid (i_dir_valid),
    .edge_c      (edge_c),
    .tol_ok_c    (tol_ok_c),
    .dec_c       (dec_c),
    .dec_bit_c   (dec_bit_c),
    .run_lost_c  (run_lost_c)
  );

  assign sfd_nx_c = {dec_bit_c, sfd_q[7:1]};
  assign byte_c   = {dec_bit_c, pk_q[BYTE_W-1:1]};

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    sof_c   = 1'b0;
    eof_c   = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      SEARCH: begin
        if (edge_c && tol_ok_c && (sync_q == SC_W'(SYNC_LEN - 1))) state_d = TRACK;
      end
      TRACK: begin
        if (run_lost_c) begin
          state_d = SEARCH;
        end else if (dec_c && (sfd_nx_c == SFD)) begin
          sof_c   = 1'b1;
          state_d = FRAME;
        end
      end
      FRAME: begin
        if (run_lost_c) begin
          state_d = SEARCH;
        end else if (dec_c && (bcnt_q == BC_W'(BYTE_W - 1))) begin
          done_c = 1'b1;
          if (hdr_q ? (byte_c[LEN_W-1:0] == '0) : (rem_q == LEN_W'(1))) begin
            eof_c   = 1'b1;
            state_d = TRACK;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= SEARCH;
      sync_q       <= '0;
      sfd_q        <= '0;
      pk_q         <= '0;
      bcnt_q       <= '0;
      hdr_q        <= 1'b0;
      rem_q        <= '0;
      o_bit        <= 1'b0;
      o_bit_valid  <= 1'b0;
      o_locked     <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_locked    <= (state_d != SEARCH);
      o_sof       <= sof_c;
      o_eof       <= eof_c;
      o_bit_valid <= dec_c && (state_q != SEARCH);
      if (dec_c && (state_q != SEARCH)) o_bit <= dec_bit_c;

      if (state_q != SEARCH) begin
        sync_q <= '0;
      end else if (edge_c) begin
        sync_q <= tol_ok_c ? sync_q + SC_W'(1) : '0;
      end

      // SFD window restarts empty every time TRACK is (re)entered.
      if (state_d != TRACK) begin
        sfd_q <= '0;
      end else if ((state_q == TRACK) && dec_c) begin
        sfd_q <= sfd_nx_c;
      end

      if (sof_c) begin
        pk_q   <= '0;
        bcnt_q <= '0;
        hdr_q  <= 1'b1;
      end else if ((state_q == FRAME) && dec_c && !run_lost_c) begin
        pk_q   <= byte_c;
        bcnt_q <= done_c ? '0 : bcnt_q + BC_W'(1);
        if (done_c) begin
          hdr_q <= 1'b0;
          rem_q <= hdr_q ? byte_c[LEN_W-1:0] : rem_q - LEN_W'(1);
        end
      end

      // A held, unaccepted byte wins over a newly completed one.
      if (done_c && (!o_data_valid || i_data_ready)) begin
        o_data       <= byte_c;
        o_data_valid <= 1'b1;
      end else begin
        if (done_c) o_overflow <= 1'b1;
        if (o_data_valid && i_data_ready) o_data_valid <= 1'b0;
      end
    end
  end

`ifdef RX_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      if (eof_c && (o_frame_cnt != 16'hFFFF)) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (done_c && o_data_valid && !i_data_ready && (o_drop_cnt != 16'hFFFF)) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
